trace_capture_buffer: RTL and testbench

//  Synthesizable on-chip trace recorder for the single-cycle MIPS core. Each retired instruction

---
 rtl/trace_capture_buffer.sv | 189 ++++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// Commit-stream trace recorder: circular buffer with pre-trigger history,
// immediate or PC-match trigger, then an oldest-first valid/ready drain.
module trace_capture_buffer #(
    parameter  int DEPTH  = 64,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int REG_AW = 5,
    parameter  int CNT_W  = 16,
    localparam int PW     = $clog2(DEPTH),
    localparam int LW     = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_pc,
    input  logic [DATA_W-1:0] commit_instr,
    input  logic              rf_we,
    input  logic [REG_AW-1:0] rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_mode,
    input  logic [ADDR_W-1:0] trig_pc,
    input  logic [CNT_W-1:0]  post_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic              out_we,
    output logic [REG_AW-1:0] out_waddr,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_last,
    output logic [1:0]        state,
    output logic [LW-1:0]     level,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } rec_t;

    rec_t mem [DEPTH];

    state_t            state_q, state_d;
    logic [LW-1:0]     level_q, level_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] tpc_q, tpc_d;
    logic [CNT_W-1:0]  post_q, post_d;
    logic              wen;
    logic              full;
    logic              hit;
    rec_t              cur;

    assign full = (level_q == LW'(DEPTH));
    assign hit  = ~mode_q | (commit_pc == tpc_q);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        pcnt_d  = pcnt_q;
        mode_d  = mode_q;
        tpc_d   = tpc_q;
        post_d  = post_q;
        wen     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    level_d = '0;
                    wr_d    = '0;
                    rd_d    = '0;
                    ovf_d   = 1'b0;
                    pcnt_d  = '0;
                    mode_d  = trig_mode;
                    tpc_d   = trig_pc;
                    post_d  = post_count;
                end
            end
            ARMED: begin
                if (commit_valid) begin
                    wen    = 1'b1;
                    pcnt_d = '0;
                    if (hit)
                        state_d = (post_q == '0) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                if (commit_valid) begin
                    wen    = 1'b1;
                    pcnt_d = pcnt_q + 1'b1;
                    if (pcnt_d == post_q)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (level_q == '0) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    rd_d    = rd_q + 1'b1;
                    level_d = level_q - 1'b1;
                    if (level_q == LW'(1))
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A write into a full ring drops the oldest record
        if (wen) begin
            wr_d = wr_q + 1'b1;
            if (full) begin
                rd_d  = rd_q + 1'b1;
                ovf_d = 1'b1;
            end else begin
                level_d = level_q + 1'b1;
            end
        end
        if (abort) begin
            state_d = IDLE;
            level_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            ovf_d   = 1'b0;
            pcnt_d  = '0;
            wen     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            level_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            pcnt_q  <= '0;
            mode_q  <= 1'b0;
            tpc_q   <= '0;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
            pcnt_q  <= pcnt_d;
            mode_q  <= mode_d;
            tpc_q   <= tpc_d;
            post_q  <= post_d;
        end
    end

    // Storage carries no reset; the output gating below hides stale slots
    always_ff @(posedge clk) begin
        if (wen)
            mem[wr_q] <= '{pc: commit_pc, instr: commit_instr, we: rf_we,
                           waddr: rf_waddr, wdata: rf_wdata};
    end

    assign cur       = mem[rd_q];
    assign out_valid = (state_q == DRAIN) && (level_q != '0);
    assign out_last  = out_valid && (level_q == LW'(1));
    assign out_pc    = out_valid ? cur.pc    : '0;
    assign out_instr = out_valid ? cur.instr : '0;
    assign out_we    = out_valid ? cur.we    : 1'b0;
    assign out_waddr = out_valid ? cur.waddr : '0;
    assign out_wdata = out_valid ? cur.wdata : '0;
    assign state     = state_q;
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: per-cycle vector table plus
// hand sequences for wrap/overflow, drain stalls and async reset.
module tb_trace_capture_buffer;

    logic        clk;
    logic        reset;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_instr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        arm;
    logic        abort;
    logic        trig_mode;
    logic [31:0] trig_pc;
    logic [15:0] post_count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_we;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;
    logic        out_last;
    logic [1:0]  state;
    logic [6:0]  level;
    logic        overflow;

    int nvec = 0;
    int nmis = 0;

    trace_capture_buffer dut (
        .clk(clk), .reset(reset),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_instr(commit_instr), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .arm(arm), .abort(abort), .trig_mode(trig_mode),
        .trig_pc(trig_pc), .post_count(post_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_we(out_we),
        .out_waddr(out_waddr), .out_wdata(out_wdata),
        .out_last(out_last), .state(state), .level(level),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arm, abort, cv;
        logic [31:0] pc;
        logic        mode;
        logic [31:0] tpc;
        logic [15:0] post;
        logic        rdy;
        logic [1:0]  st;
        logic [6:0]  lvl;
        logic        vld, last, ovf;
        logic [31:0] opc;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(
        input logic a, input logic ab, input logic cv, input logic [31:0] pc,
        input logic m, input logic [31:0] tpc, input logic [15:0] post,
        input logic rdy, input logic [1:0] st, input logic [6:0] lvl,
        input logic vld, input logic last, input logic ovf,
        input logic [31:0] opc);
        vec_t v;
        v.arm = a; v.abort = ab; v.cv = cv; v.pc = pc; v.mode = m;
        v.tpc = tpc; v.post = post; v.rdy = rdy; v.st = st; v.lvl = lvl;
        v.vld = vld; v.last = last; v.ovf = ovf; v.opc = opc;
        return v;
    endfunction

    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [31:0] pc);
        return ~pc;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input logic v,
                           input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".pc"},    out_pc,    v ? pc : 32'h0);
        chk({tag, ".instr"}, out_instr, v ? f_instr(pc) : 32'h0);
        chk({tag, ".we"},    32'(out_we),    v ? 32'(pc[2]) : 32'h0);
        chk({tag, ".waddr"}, 32'(out_waddr), v ? 32'(pc[6:2]) : 32'h0);
        chk({tag, ".wdata"}, out_wdata, v ? f_wdata(pc) : 32'h0);
    endtask

    task automatic idle_in();
        commit_valid = 1'b0; commit_pc = '0; commit_instr = '0;
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        arm = 1'b0; abort = 1'b0; out_ready = 1'b0;
    endtask

    task automatic commit_in(input logic [31:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_instr = f_instr(pc);
        rf_we        = pc[2];
        rf_waddr     = pc[6:2];
        rf_wdata     = f_wdata(pc);
    endtask

    task automatic cfg(input logic m, input logic [31:0] tpc,
                       input logic [15:0] post);
        trig_mode = m; trig_pc = tpc; post_count = post;
    endtask

    task automatic arm_cycle(input logic m, input logic [31:0] tpc,
                             input logic [15:0] post);
        @(negedge clk);
        idle_in();
        cfg(m, tpc, post);
        arm = 1'b1;
        @(posedge clk);
    endtask

    task automatic commit_cycle(input logic [31:0] pc);
        @(negedge clk);
        idle_in();
        commit_in(pc);
        @(posedge clk);
    endtask

    initial begin
        int k;
        int step;
        logic rdy;

        reset = 1'b0;
        idle_in();
        cfg(1'b0, 32'h0, 16'h0);
        #2;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.ovf",   32'(overflow), 32'd0);
        chk("rst.last",  32'(out_last), 32'd0);
        chk_rec("rst", 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // arm abt cv pc      m tpc     post rdy st lvl vld lst ovf opc
        tbl[0]  = mk(1,0,0,32'h00, 0,32'h0, 3, 0, 1,0, 0,0,0,32'h00);
        tbl[1]  = mk(0,0,1,32'h00, 0,32'h0, 3, 0, 2,1, 0,0,0,32'h00);
        tbl[2]  = mk(0,0,1,32'h04, 0,32'h0, 3, 0, 2,2, 0,0,0,32'h00);
        tbl[3]  = mk(0,0,1,32'h08, 0,32'h0, 3, 0, 2,3, 0,0,0,32'h00);
        tbl[4]  = mk(0,0,1,32'h0C, 0,32'h0, 3, 0, 3,4, 1,0,0,32'h00);
        tbl[5]  = mk(0,0,1,32'h10, 0,32'h0, 3, 0, 3,4, 1,0,0,32'h00);
        tbl[6]  = mk(0,0,0,32'h00, 0,32'h0, 3, 1, 3,3, 1,0,0,32'h04);
        tbl[7]  = mk(0,0,0,32'h00, 0,32'h0, 3, 1, 3,2, 1,0,0,32'h08);
        tbl[8]  = mk(0,0,0,32'h00, 0,32'h0, 3, 1, 3,1, 1,1,0,32'h0C);
        tbl[9]  = mk(0,0,0,32'h00, 0,32'h0, 3, 1, 0,0, 0,0,0,32'h00);
        tbl[10] = mk(0,0,0,32'h00, 0,32'h0, 3, 1, 0,0, 0,0,0,32'h00);
        tbl[11] = mk(1,0,1,32'h40, 0,32'h0, 0, 0, 1,0, 0,0,0,32'h00);
        tbl[12] = mk(0,0,1,32'h44, 0,32'h0, 0, 0, 3,1, 1,1,0,32'h44);
        tbl[13] = mk(0,0,0,32'h00, 0,32'h0, 0, 1, 0,0, 0,0,0,32'h00);
        tbl[14] = mk(1,0,0,32'h00, 0,32'h0, 5, 0, 1,0, 0,0,0,32'h00);
        tbl[15] = mk(0,0,1,32'h80, 0,32'h0, 5, 0, 2,1, 0,0,0,32'h00);
        tbl[16] = mk(1,0,1,32'h84, 0,32'h0, 0, 0, 2,2, 0,0,0,32'h00);
        tbl[17] = mk(1,1,1,32'h88, 0,32'h0, 0, 1, 0,0, 0,0,0,32'h00);
        tbl[18] = mk(1,0,0,32'h00, 0,32'h0, 0, 0, 1,0, 0,0,0,32'h00);
        tbl[19] = mk(0,0,1,32'h90, 0,32'h0, 0, 0, 3,1, 1,1,0,32'h90);
        tbl[20] = mk(0,0,0,32'h00, 0,32'h0, 0, 1, 0,0, 0,0,0,32'h00);
        tbl[21] = mk(1,0,0,32'h00, 1,32'h30,1, 0, 1,0, 0,0,0,32'h00);
        tbl[22] = mk(0,0,1,32'h20, 1,32'h30,1, 0, 1,1, 0,0,0,32'h00);
        tbl[23] = mk(0,0,1,32'h30, 1,32'h30,1, 0, 2,2, 0,0,0,32'h00);
        tbl[24] = mk(0,0,1,32'h34, 1,32'h30,1, 0, 3,3, 1,0,0,32'h20);
        tbl[25] = mk(0,0,0,32'h00, 1,32'h30,1, 1, 3,2, 1,0,0,32'h30);
        tbl[26] = mk(0,0,0,32'h00, 1,32'h30,1, 1, 3,1, 1,1,0,32'h34);
        tbl[27] = mk(0,0,0,32'h00, 1,32'h30,1, 1, 0,0, 0,0,0,32'h00);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            idle_in();
            cfg(tbl[i].mode, tbl[i].tpc, tbl[i].post);
            arm       = tbl[i].arm;
            abort     = tbl[i].abort;
            out_ready = tbl[i].rdy;
            if (tbl[i].cv)
                commit_in(tbl[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("v%0d.level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("v%0d.last", i), 32'(out_last), 32'(tbl[i].last));
            chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            chk_rec($sformatf("v%0d", i), tbl[i].vld, tbl[i].opc);
        end

        // Wrap with overflow: PC-match at 0x100, two post records
        arm_cycle(1'b1, 32'h100, 16'd2);
        for (int i = 0; i < 100; i++)
            commit_cycle(32'(4 * i));
        @(negedge clk);
        idle_in();
        chk("t2.state", 32'(state), 32'd3);
        chk("t2.level", 32'(level), 32'd64);
        chk("t2.ovf",   32'(overflow), 32'd1);
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            idle_in();
            out_ready = 1'b1;
            chk_rec($sformatf("t2.r%0d", j), 1'b1, 32'(32'hC + 4 * j));
            chk($sformatf("t2.last%0d", j), 32'(out_last), 32'(j == 63));
            @(posedge clk);
        end
        @(negedge clk);
        idle_in();
        chk("t2.end.state", 32'(state), 32'd0);
        chk("t2.end.valid", 32'(out_valid), 32'd0);

        // Stalled drain: ready pattern 1,0,0,1,0,0,...
        arm_cycle(1'b0, 32'h0, 16'd4);
        for (int i = 0; i < 5; i++)
            commit_cycle(32'(32'h200 + 4 * i));
        k = 0;
        step = 0;
        while (k < 5 && step < 30) begin
            @(negedge clk);
            idle_in();
            rdy = (step % 3 == 0);
            out_ready = rdy;
            chk_rec($sformatf("t3.s%0d", step), 1'b1, 32'(32'h200 + 4 * k));
            chk($sformatf("t3.last%0d", step), 32'(out_last), 32'(k == 4));
            @(posedge clk);
            if (rdy)
                k++;
            step++;
        end
        @(negedge clk);
        idle_in();
        chk("t3.xfers", 32'(k), 32'd5);
        chk("t3.state", 32'(state), 32'd0);
        chk("t3.valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a drain
        arm_cycle(1'b0, 32'h0, 16'd6);
        for (int i = 0; i < 7; i++)
            commit_cycle(32'(32'h300 + 4 * i));
        @(negedge clk);
        idle_in();
        chk("t5.pre.level", 32'(level), 32'd7);
        chk("t5.pre.state", 32'(state), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("t5.state", 32'(state), 32'd0);
        chk("t5.level", 32'(level), 32'd0);
        chk("t5.ovf",   32'(overflow), 32'd0);
        chk("t5.last",  32'(out_last), 32'd0);
        chk_rec("t5", 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        arm_cycle(1'b0, 32'h0, 16'd0);
        commit_cycle(32'h400);
        @(negedge clk);
        idle_in();
        chk("t5.post.state", 32'(state), 32'd3);
        chk("t5.post.level", 32'(level), 32'd1);
        chk("t5.post.last",  32'(out_last), 32'd1);
        chk_rec("t5.post", 1'b1, 32'h400);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
